// File: rtl/bcd_scan_if.sv
// Handshake and display bus of the BCD scan controller.
// Producer side: load_*, decoder side: dec_*, display side: digit_*.
interface bcd_scan_if;
  logic       load_valid;
  logic [3:0] load_data;
  logic       load_ready;
  logic [3:0] dec_data;
  logic [7:0] dec_bcd;
  logic [1:0] digit_sel;
  logic [3:0] digit_val;
  logic       busy;
  logic       err;

  modport master (
    output load_valid, load_data, dec_bcd,
    input  load_ready, dec_data, digit_sel,
    input  digit_val, busy, err
  );

  modport slave (
    input  load_valid, load_data, dec_bcd,
    output load_ready, dec_data, digit_sel,
    output digit_val, busy, err
  );
endinterface

// File: rtl/bcd_scan_ctrl.sv
// Two-digit BCD scan controller: loads a value, runs it through the
// shared decoder, then alternates units/tens digits every DIV cycles.
// Ports: clk, rst_n (async low), bus (bcd_scan_if.slave).
// Option: LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module bcd_scan_ctrl #(
  parameter int DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  bcd_scan_if.slave   bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    IDLE, DECODE, SCAN_LO, SCAN_HI
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    val_q;
  logic [7:0]    bcd_q;
  logic          err_q;
  logic          last;
  logic          ready;
  logic          xfer;
  logic          blank_hi;
  logic          bad_bcd;

  assign last  = (cnt_q == CW'(DIV - 1));
  assign ready = (state_q == IDLE) ||
                 ((state_q == SCAN_HI) && last);
  assign xfer  = bus.load_valid && ready;

  assign bad_bcd = (bus.dec_bcd[7:4] > 4'd9) ||
                   (bus.dec_bcd[3:0] > 4'd9);

`ifdef LEADING_ZERO_BLANK_EN
  assign blank_hi = (bcd_q[7:4] == 4'd0);
`else
  assign blank_hi = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      bcd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (xfer)
        val_q <= bus.load_data;
      if (state_q == DECODE) begin
        bcd_q <= bus.dec_bcd;
        err_q <= bad_bcd;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (xfer)
          state_d = DECODE;
      end
      DECODE: begin
        cnt_d   = '0;
        state_d = SCAN_LO;
      end
      SCAN_LO: begin
        if (last) begin
          cnt_d   = '0;
          state_d = SCAN_HI;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SCAN_HI: begin
        if (last) begin
          cnt_d   = '0;
          state_d = xfer ? DECODE : SCAN_LO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.digit_sel = 2'b00;
    bus.digit_val = 4'd0;
    bus.busy      = 1'b1;
    unique case (1'b1)
      (state_q == IDLE): begin
        bus.busy = 1'b0;
      end
      (state_q == SCAN_LO): begin
        bus.digit_val = bcd_q[3:0];
        if (!err_q)
          bus.digit_sel = 2'b01;
      end
      (state_q == SCAN_HI): begin
        bus.digit_val = bcd_q[7:4];
        if (!err_q && !blank_hi)
          bus.digit_sel = 2'b10;
      end
      default: ;
    endcase
  end

  assign bus.load_ready = ready;
  assign bus.dec_data   = val_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Testbench for bcd_scan_ctrl: directed and random loads
// checked cycle by cycle against a slot-arithmetic model.
module tb_bcd_scan_ctrl;

  localparam int DIV = 4;
  localparam int PER = 2 * DIV;

  logic clk = 1'b0;
  logic rst_n;
  bit   clk_en = 1'b0;

  bcd_scan_if bus ();

  bcd_scan_ctrl #(.DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  logic       ovr_en;
  logic [7:0] ovr_val;

  function automatic logic [7:0] tobcd(input logic [3:0] d);
    int t, u;
    t = int'(d) / 10;
    u = int'(d) % 10;
    return {4'(t), 4'(u)};
  endfunction

  assign bus.dec_bcd = ovr_en ? ovr_val : tobcd(bus.dec_data);

  int tests = 0;
  int fails = 0;

  // model: idle flag, loaded value, captured bcd, error flag,
  // cycles elapsed since the transfer edge (0 = DECODE cycle)
  bit         m_idle;
  logic [3:0] m_v;
  logic [7:0] m_b;
  bit         m_err;
  int         m_k;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idle = 1'b1;
    m_v    = 4'd0;
    m_b    = 8'd0;
    m_err  = 1'b0;
    m_k    = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".ready"}, 8'(bus.load_ready), 8'd1);
    chk({tag, ".sel"},   8'(bus.digit_sel),  8'd0);
    chk({tag, ".val"},   8'(bus.digit_val),  8'd0);
    chk({tag, ".dec"},   8'(bus.dec_data),   8'd0);
    chk({tag, ".busy"},  8'(bus.busy),       8'd0);
    chk({tag, ".err"},   8'(bus.err),        8'd0);
  endtask

  // slot position within a scan period, -1 outside scanning
  function automatic int pos();
    if (m_idle || m_k == 0) return -1;
    return (m_k - 1) % PER;
  endfunction

  task automatic run(input int n);
    logic [1:0] e_sel;
    logic [3:0] e_val;
    bit         e_rdy, e_busy, lo;
    int         p;
    for (int i = 0; i < n; i++) begin
      p      = pos();
      e_sel  = 2'b00;
      e_val  = 4'd0;
      e_rdy  = m_idle;
      e_busy = !m_idle;
      if (p >= 0) begin
        lo    = (p < DIV);
        e_val = lo ? m_b[3:0] : m_b[7:4];
        e_rdy = (p == PER - 1);
        if (!m_err) begin
          if (lo)
            e_sel = 2'b01;
`ifdef LEADING_ZERO_BLANK_EN
          else if (m_b[7:4] != 4'd0)
            e_sel = 2'b10;
`else
          else
            e_sel = 2'b10;
`endif
        end
      end
      chk("sel",   8'(bus.digit_sel),  8'(e_sel));
      chk("val",   8'(bus.digit_val),  8'(e_val));
      chk("ready", 8'(bus.load_ready), 8'(e_rdy));
      chk("busy",  8'(bus.busy),       8'(e_busy));
      chk("dec",   8'(bus.dec_data),   8'(m_v));
      chk("err",   8'(bus.err),        8'(m_err));
      if (!m_idle && m_k == 0) begin
        m_b   = ovr_en ? ovr_val : tobcd(m_v);
        m_err = (m_b[7:4] > 4'd9) || (m_b[3:0] > 4'd9);
      end
      if (e_rdy && bus.load_valid) begin
        m_idle = 1'b0;
        m_v    = bus.load_data;
        m_k    = 0;
      end else if (!m_idle) begin
        m_k++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n          = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = 4'd0;
    ovr_en         = 1'b0;
    ovr_val        = 8'h00;
    model_reset();

    // reset without a running clock
    #1 rst_n = 1'b0;
    #2 chk_reset("rst0");
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(2);

    // load 13, observe several scan periods
    bus.load_valid = 1'b1;
    bus.load_data  = 4'd13;
    run(1);
    bus.load_valid = 1'b0;
    run(3 * PER + 1);

    // hold 9 while scanning: single transfer on last tens cycle
    bus.load_valid = 1'b1;
    bus.load_data  = 4'd9;
    run(PER);
    bus.load_valid = 1'b0;
    run(PER + 3);

    // single-digit value: tens slot shows 0 or is blanked
    bus.load_valid = 1'b1;
    bus.load_data  = 4'd7;
    run(PER);
    bus.load_valid = 1'b0;
    run(2 * PER);

    // bad decoder output sets err and blanks both slots
    ovr_en         = 1'b1;
    ovr_val        = 8'hFF;
    bus.load_valid = 1'b1;
    bus.load_data  = 4'd5;
    run(PER);
    bus.load_valid = 1'b0;
    run(PER + 2);
    ovr_en = 1'b0;
    run(PER);

    // good reload clears err
    bus.load_valid = 1'b1;
    bus.load_data  = 4'd5;
    run(PER);
    bus.load_valid = 1'b0;
    run(PER + 2);

    // random traffic including occasional bad decoder output
    for (int i = 0; i < 150; i++) begin
      bus.load_valid = ($urandom_range(0, 3) == 0);
      bus.load_data  = 4'($urandom_range(0, 15));
      ovr_en         = ($urandom_range(0, 7) == 0);
      ovr_val        = 8'($urandom);
      run(1);
    end
    bus.load_valid = 1'b0;
    ovr_en         = 1'b0;

    // make sure something is scanning, then reset mid tens slot
    bus.load_valid = 1'b1;
    bus.load_data  = 4'd12;
    for (int i = 0; i < 4 * PER; i++) begin
      if (!m_idle && pos() == DIV + 1) break;
      if (!m_idle && m_k > 0) bus.load_valid = 1'b0;
      run(1);
    end
    bus.load_valid = 1'b0;
    chk("midhi", 8'(pos()), 8'(DIV + 1));
    #2 rst_n = 1'b0;
    #1 chk_reset("rst1");
    model_reset();
    @(posedge clk);
    #1 chk_reset("rst2");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(4);

    // block resumes after reset
    bus.load_valid = 1'b1;
    bus.load_data  = 4'd10;
    run(1);
    bus.load_valid = 1'b0;
    run(PER + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_scan_ctrl.md
# bcd_scan_ctrl

Scan controller that sequences the shared 4-bit binary-to-BCD decoder and time-multiplexes its two BCD digits onto a two-digit display. It accepts a binary value through a valid/ready handshake, drives the decoder input, captures the decoder's 8-bit BCD result, and then refreshes the units and tens digits alternately, each for a programmable number of cycles. It sits between the value producer and the segment driver; the decoder itself stays outside this block.

## Interface
- DIV, 4, cycles each digit is shown per scan slot; legal range 1..255
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- load_valid  in  1  producer has a value on load_data
- load_data  in  4  binary value 0..15
- load_ready  out  1  block accepts load_data this cycle
- dec_data  out  4  drives the shared decoder input
- dec_bcd  in  8  decoder output; [7:4] tens, [3:0] units
- digit_sel  out  2  one-hot digit enable; [0] units, [1] tens; 00 = blank
- digit_val  out  4  BCD nibble for the enabled digit
- busy  out  1  a value is loaded and being scanned
- err  out  1  captured BCD had a nibble > 9

## Operation
- States: IDLE, DECODE, SCAN_LO, SCAN_HI.
- A transfer occurs on a rising edge where load_valid && load_ready; load_data is registered into val_q.
- IDLE: load_ready=1, digit_sel=00, busy=0. A transfer moves to DECODE.
- DECODE (1 cycle): dec_data=val_q, load_ready=0. At the end of the cycle, dec_bcd is captured into bcd_q and err is set if bcd_q[7:4]>9 or bcd_q[3:0]>9; otherwise err is cleared. The next state is SCAN_LO.
- SCAN_LO (DIV cycles): digit_sel=01, digit_val=bcd_q[3:0]. Then moves to SCAN_HI.
- SCAN_HI (DIV cycles): digit_sel=10, digit_val=bcd_q[7:4]. load_ready=1 only on the final cycle of this slot. A transfer on that cycle moves to DECODE; otherwise the state returns to SCAN_LO and the scan repeats indefinitely.
- When err=1, digit_sel=00 in SCAN_LO and SCAN_HI. Slot timing continues and busy stays 1.
- dec_data holds val_q in every state except after reset, where it is 0.
- busy=1 in DECODE, SCAN_LO and SCAN_HI.
- Slot counter: width max(1, clog2(DIV)); cleared on entry to each SCAN state; the slot ends when count==DIV-1.
- DIV=1 means the display alternates digits every cycle, and load_ready is high on every SCAN_HI cycle.
- load_valid is ignored in DECODE, SCAN_LO, and in SCAN_HI before its final cycle. The producer must hold load_valid and load_data until the transfer occurs.

## Timing
- Reset (async assert, sync release):
  - state IDLE
  - load_ready=1
  - digit_sel=00, digit_val=0, dec_data=0
  - busy=0, err=0
  - val_q=0, bcd_q=0, counter=0
- Asserting rst_n mid-scan forces these values immediately, without waiting for clk.
- All outputs are registered or decoded from state only. There is no combinational path from load_valid to any output.
- Latency, transfer at edge T:
  - DECODE during cycle T+1
  - units digit visible from cycle T+2 through T+1+DIV
  - tens digit visible from T+2+DIV through T+1+2·DIV
- Reload: a transfer on the final SCAN_HI cycle makes the next cycle DECODE, with digit_sel=00 for that one cycle. The new units digit appears one cycle after that.
- The decoder is combinational. dec_bcd must be valid within the DECODE cycle.

## Configuration
- LEADING_ZERO_BLANK_EN
  - Defined: in SCAN_HI, if bcd_q[7:4]==0, digit_sel=00 for the whole slot. Slot length and load_ready timing are unchanged.
  - Undefined: the tens digit is always enabled and shows 0 for values 0..9.

## Test plan
- Reset: pulse rst_n low with no clock running -> load_ready=1, digit_sel=00, busy=0, err=0, dec_data=0.
- DIV=4, load 4'd13 with decoder 8'h13 -> DECODE shows dec_data=13. Then 4 cycles of digit_sel=01/digit_val=3, then 4 cycles of digit_sel=10/digit_val=1, repeating; busy=1 throughout.
- DIV=4, load 4'd7 with decoder 8'h07 -> with LEADING_ZERO_BLANK_EN, SCAN_HI slot shows digit_sel=00. Without it, digit_sel=10 and digit_val=0.
- Hold load_valid=1 with load_data=9 while scanning 13 -> load_ready pulses only on the last SCAN_HI cycle. The transfer occurs there, then DECODE, then digit_sel=01/digit_val=9.
- Force dec_bcd=8'hFF during DECODE -> err=1, digit_sel=00 in both slots while slot timing continues. Reloading with a good value (8'h05) clears err.
- Assert rst_n in the middle of a SCAN_HI slot -> outputs return to reset values asynchronously. After release, the block stays in IDLE until the next transfer.
